// File: rtl/hough_pkg.sv
// Shared types for the Hough front-end geometry logic.
package hough_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRACK,
        ST_LOCKED
    } geom_state_e;

    localparam int unsigned MATCH_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 12
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    localparam logic [W-1:0] MAX_VAL = '1;

    logic [W-1:0] r_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != MAX_VAL)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q   = r_q;
    assign sat = (r_q == MAX_VAL);

endmodule

// File: rtl/line_geometry.sv
// Stream geometry monitor: measures line width with a lock state machine
// and frame height between frame-end strobes.
module line_geometry
    import hough_pkg::*;
#(
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             Clear,
    input  logic             Valid,
    input  logic             Line,
    input  logic             Frame,
    output logic [CNT_W-1:0] Width,
    output logic             Locked,
    output logic             Mismatch,
    output logic [CNT_W-1:0] Height,
    output logic             HValid,
    output logic             Overflow
);

    localparam logic [CNT_W-1:0]   MAX_VAL    = '1;
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_LINES - 1);

    logic               w_line_ev;
    logic               w_frame_ev;
    logic [CNT_W-1:0]   w_pcnt;
    logic               w_psat;
    logic [CNT_W-1:0]   w_lcnt;
    logic               w_lsat;
    logic [CNT_W-1:0]   w_meas;
    logic [CNT_W-1:0]   w_height;

    geom_state_e        r_state,    w_state_nxt;
    logic [CNT_W-1:0]   r_cand,     w_cand_nxt;
    logic [MATCH_W-1:0] r_match,    w_match_nxt;
    logic [CNT_W-1:0]   r_width,    w_width_nxt;
    logic               r_locked,   w_locked_nxt;
    logic               r_mismatch, w_mismatch_nxt;
    logic [CNT_W-1:0]   r_height,   w_height_nxt;
    logic               r_hvalid,   w_hvalid_nxt;
    logic               r_overflow, w_overflow_nxt;
    logic               r_armed,    w_armed_nxt;

    assign w_line_ev  = Valid & Line;
    assign w_frame_ev = w_line_ev & Frame;

    sat_counter #(.W(CNT_W)) u_pcnt (
        .Clk    (Clk),
        .nReset (nReset),
        .inc    (Valid & ~Line),
        .clr    (Clear | w_line_ev),
        .q      (w_pcnt),
        .sat    (w_psat)
    );

    sat_counter #(.W(CNT_W)) u_lcnt (
        .Clk    (Clk),
        .nReset (nReset),
        .inc    (w_line_ev & ~Frame),
        .clr    (Clear | w_frame_ev),
        .q      (w_lcnt),
        .sat    (w_lsat)
    );

    // The line-end beat itself is counted, hence the +1 on both measurements.
    assign w_meas   = w_psat ? MAX_VAL : (w_pcnt + CNT_W'(1));
    assign w_height = w_lsat ? MAX_VAL : (w_lcnt + CNT_W'(1));

    always_comb begin
        w_state_nxt    = r_state;
        w_cand_nxt     = r_cand;
        w_match_nxt    = r_match;
        w_width_nxt    = r_width;
        w_locked_nxt   = r_locked;
        w_mismatch_nxt = 1'b0;
        w_height_nxt   = r_height;
        w_hvalid_nxt   = r_hvalid;
        w_armed_nxt    = r_armed;
        w_overflow_nxt = r_overflow | (Valid & w_psat)
                       | (w_line_ev & ~Frame & w_lsat)
                       | (w_frame_ev & r_armed & w_lsat);

        case (r_state)
            ST_IDLE: begin
                // First line after reset is partial; drop it.
                if (w_line_ev) begin
                    w_state_nxt = ST_TRACK;
                    w_match_nxt = '0;
                end
            end
            ST_TRACK: begin
                if (w_line_ev) begin
                    if ((r_match == '0) || (w_meas != r_cand)) begin
                        w_cand_nxt  = w_meas;
                        w_match_nxt = MATCH_W'(1);
                    end else if (r_match == MATCH_LOCK) begin
                        w_state_nxt  = ST_LOCKED;
                        w_width_nxt  = r_cand;
                        w_locked_nxt = 1'b1;
                    end else begin
                        w_match_nxt = r_match + MATCH_W'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (w_line_ev && (w_meas != r_width)) begin
                    w_state_nxt    = ST_TRACK;
                    w_cand_nxt     = w_meas;
                    w_match_nxt    = MATCH_W'(1);
                    w_locked_nxt   = 1'b0;
                    w_mismatch_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_frame_ev) begin
            w_armed_nxt = 1'b1;
            if (r_armed) begin
                w_height_nxt = w_height;
                w_hvalid_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_state    <= ST_IDLE;
            r_cand     <= '0;
            r_match    <= '0;
            r_width    <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_height   <= '0;
            r_hvalid   <= 1'b0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else if (Clear) begin
            r_state    <= ST_IDLE;
            r_cand     <= '0;
            r_match    <= '0;
            r_width    <= '0;
            r_locked   <= 1'b0;
            r_mismatch <= 1'b0;
            r_height   <= '0;
            r_hvalid   <= 1'b0;
            r_overflow <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cand     <= w_cand_nxt;
            r_match    <= w_match_nxt;
            r_width    <= w_width_nxt;
            r_locked   <= w_locked_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_height   <= w_height_nxt;
            r_hvalid   <= w_hvalid_nxt;
            r_overflow <= w_overflow_nxt;
            r_armed    <= w_armed_nxt;
        end
    end

    assign Width    = r_width;
    assign Locked   = r_locked;
    assign Mismatch = r_mismatch;
    assign Height   = r_height;
    assign HValid   = r_hvalid;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_line_geometry.sv
// Self-checking bench for line_geometry: run-length reference model plus
// directed scenarios and randomized line/frame traffic.
module tb_line_geometry;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LOCK_LINES = 3;
    localparam int          MAXV       = 255;

    logic             Clk    = 1'b0;
    logic             nReset = 1'b0;
    logic             Clear  = 1'b0;
    logic             Valid  = 1'b0;
    logic             Line   = 1'b0;
    logic             Frame  = 1'b0;
    logic [CNT_W-1:0] Width;
    logic             Locked;
    logic             Mismatch;
    logic [CNT_W-1:0] Height;
    logic             HValid;
    logic             Overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: true (unbounded) counts, clipped only when reported.
    int m_pw, m_lc, m_run, m_last, m_width, m_height;
    bit m_seen, m_locked, m_mis, m_hv, m_ovf, m_armed;

    line_geometry #(.CNT_W(CNT_W), .LOCK_LINES(LOCK_LINES)) dut (
        .Clk      (Clk),
        .nReset   (nReset),
        .Clear    (Clear),
        .Valid    (Valid),
        .Line     (Line),
        .Frame    (Frame),
        .Width    (Width),
        .Locked   (Locked),
        .Mismatch (Mismatch),
        .Height   (Height),
        .HValid   (HValid),
        .Overflow (Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pw = 0; m_lc = 0; m_run = 0; m_last = 0; m_width = 0; m_height = 0;
        m_seen = 0; m_locked = 0; m_mis = 0; m_hv = 0; m_ovf = 0; m_armed = 0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int w, meas, h;
        m_mis = 0;
        if (Clear) begin
            model_reset();
            return;
        end
        if (!Valid) return;
        if (!Line) begin
            m_pw++;
            if (m_pw > MAXV) m_ovf = 1;
            return;
        end
        w    = m_pw + 1;
        m_pw = 0;
        if (w > MAXV) begin
            m_ovf = 1;
            meas  = MAXV;
        end else begin
            meas = w;
        end
        if (!m_seen) begin
            m_seen = 1;
            m_run  = 0;
        end else if (m_locked) begin
            if (meas != m_width) begin
                m_locked = 0;
                m_mis    = 1;
                m_run    = 1;
                m_last   = meas;
            end
        end else begin
            if (m_run > 0 && meas == m_last) begin
                m_run++;
            end else begin
                m_run  = 1;
                m_last = meas;
            end
            if (m_run == int'(LOCK_LINES)) begin
                m_locked = 1;
                m_width  = meas;
            end
        end
        if (Frame) begin
            if (m_armed) begin
                h = m_lc + 1;
                if (h > MAXV) begin
                    m_ovf = 1;
                    h     = MAXV;
                end
                m_height = h;
                m_hv     = 1;
            end
            m_armed = 1;
            m_lc    = 0;
        end else begin
            m_lc++;
            if (m_lc > MAXV) m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        chk("Width",    int'(Width),    m_width);
        chk("Locked",   int'(Locked),   int'(m_locked));
        chk("Mismatch", int'(Mismatch), int'(m_mis));
        chk("Height",   int'(Height),   m_height);
        chk("HValid",   int'(HValid),   int'(m_hv));
        chk("Overflow", int'(Overflow), int'(m_ovf));
    endtask

    // Called at a falling edge: drive, step model, then check at the next falling edge.
    task automatic cyc(input logic v, input logic l, input logic f, input logic c);
        Valid = v; Line = l; Frame = f; Clear = c;
        model_step();
        @(negedge Clk);
        compare_all();
    endtask

    task automatic send_line(input int w, input logic f);
        for (int i = 0; i < w - 1; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, f, 1'b0);
    endtask

    initial begin
        int lw;
        model_reset();
        repeat (2) @(negedge Clk);
        compare_all();
        chk("reset_width_lit", int'(Width), 0);
        nReset = 1'b1;

        // Continuous lines of 10: lock only after the 4th line event.
        for (int i = 0; i < 3; i++) send_line(10, 1'b0);
        chk("pre_lock_width_lit", int'(Width), 0);
        chk("pre_lock_locked_lit", int'(Locked), 0);
        send_line(10, 1'b0);
        chk("lock10_width_lit", int'(Width), 10);
        chk("lock10_locked_lit", int'(Locked), 1);

        // Break the lock with a 12-beat line, then relock at 12.
        send_line(12, 1'b0);
        chk("break_mismatch_lit", int'(Mismatch), 1);
        chk("break_width_lit", int'(Width), 10);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("mismatch_one_cycle_lit", int'(Mismatch), 0);
        send_line(12, 1'b0);
        send_line(12, 1'b0);
        chk("relock12_width_lit", int'(Width), 12);
        chk("relock12_locked_lit", int'(Locked), 1);

        // Gapped valid; Line/Frame on idle beats must be ignored.
        for (int n = 0; n < 3; n++) begin
            for (int k = 1; k <= 10; k++) begin
                cyc(1'b1, (k == 10), 1'b0, 1'b0);
                cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            end
        end
        chk("gapped_width_lit", int'(Width), 10);

        // Pixel counter saturation.
        for (int n = 0; n < 3; n++) send_line(300, 1'b0);
        chk("sat_overflow_lit", int'(Overflow), 1);
        chk("sat_width_lit", int'(Width), 255);
        chk("sat_locked_lit", int'(Locked), 1);

        // Frame height: first frame event only arms capture.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_overflow_lit", int'(Overflow), 0);
        for (int n = 1; n <= 10; n++) begin
            send_line(3, (n % 5) == 0);
            if (n == 5) chk("first_frame_hvalid_lit", int'(HValid), 0);
        end
        chk("height_lit", int'(Height), 5);
        chk("hvalid_lit", int'(HValid), 1);

        // Clear while locked, then the next line must be discarded.
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clear_width_lit", int'(Width), 0);
        send_line(3, 1'b0);
        send_line(3, 1'b0);
        send_line(3, 1'b0);
        chk("after_clear_locked_lit", int'(Locked), 0);
        send_line(3, 1'b0);
        chk("after_clear_relock_lit", int'(Locked), 1);

        // Asynchronous reset mid-line.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        #2 nReset = 1'b0;
        #1 model_reset();
        compare_all();
        chk("async_locked_lit", int'(Locked), 0);
        @(negedge Clk);
        nReset = 1'b1;

        // Randomized traffic with repeated widths so locks form and break.
        lw = 5;
        for (int n = 0; n < 250; n++) begin
            int cnt;
            if ($urandom_range(0, 3) == 0) lw = $urandom_range(1, 12);
            if ($urandom_range(0, 59) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cnt = 0;
            while (cnt < lw) begin
                if ($urandom_range(0, 3) == 0) begin
                    cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
                end else begin
                    cnt++;
                    cyc(1'b1, (cnt == lw), 1'($urandom_range(0, 3) == 0), 1'b0);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
